display_page_sel: RTL
=====================

Name: display_page_sel

Overview:
- Parametrised successor of the time/date display selector.
- Holds a registered current page and drives N_FIELDS display fields from one of N_PAGES packed input pages.
- Page is chosen by keyboard scan codes, by timed auto-scroll, or frozen during edit with a blinking edited field.
- Sits between the counter blocks (time, date, alarm pages) and the display/VGA formatter.

Parameters:
- N_PAGES, 2, number of selectable pages; must be >= 2; page 0 = time, page 1 = date.
- N_FIELDS, 3, fields per page.
- FIELD_W, 8, width of each field; upstream zero-extends narrower counters.
- KEY_W, 8, scan-code width.
- KEY_TIME, 8'h6C, scan code selecting page 0.
- KEY_TIME_ALT, 8'h75, second scan code selecting page 0.
- KEY_DATE, 8'h72, scan code selecting page 1.
- KEY_NEXT, 8'h74, scan code advancing page by one with wrap.
- DWELL, 5, tick pulses per page in auto-scroll; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle enable pulse (1 Hz) for dwell and blink timing.
- key_code  in  KEY_W  last scan code.
- key_valid  in  1  one-cycle strobe qualifying key_code.
- auto_en  in  1  level; requests auto-scroll.
- edit_en  in  1  level; freezes page, enables blink.
- edit_field  in  clog2(N_FIELDS)  index of field being edited.
- page_data  in  N_PAGES*N_FIELDS*FIELD_W  packed pages; page p field f at bits [(p*N_FIELDS+f)*FIELD_W +: FIELD_W].
- out_fields  out  N_FIELDS*FIELD_W  registered selected fields; field f at [f*FIELD_W +: FIELD_W].
- out_page  out  clog2(N_PAGES)  current page index.
- out_blank  out  N_FIELDS  per-field blank mask; 1 = display blank.

Behaviour:
- Reset (async assert, sync deassert upstream): state MANUAL, page 0, out_fields 0, out_page 0, out_blank 0, dwell count 0, blink phase 0.
- States:
  - MANUAL, AUTO, EDIT.
  - Priority each cycle: edit_en → EDIT; else auto_en → AUTO; else MANUAL.
  - Page is retained across all state changes.
- MANUAL and AUTO, on key_valid:
  - KEY_TIME or KEY_TIME_ALT → page 0.
  - KEY_DATE → page 1.
  - KEY_NEXT → page+1, wrapping N_PAGES-1 → 0.
  - Any other code: no change.
- AUTO:
  - Dwell counter increments on tick.
  - When the counter reaches DWELL-1 and tick is high: page+1 with wrap, counter cleared.
  - A key in the same cycle as a dwell advance wins: key page is applied, counter cleared.
  - Any accepted key clears the counter.
  - Entering AUTO clears the counter.
- EDIT:
  - key_valid is ignored for page selection; page is frozen; dwell counter held at 0.
  - Blink phase toggles on each tick.
  - out_blank[edit_field] = blink phase; all other bits 0.
  - edit_field >= N_FIELDS → out_blank all 0.
  - Leaving EDIT clears blink phase, and out_blank is 0 on the next cycle.
- Latency:
  - Page register updates 1 cycle after key_valid or tick.
  - out_fields and out_page are registered from the page register and page_data; the new page is visible 2 cycles after the key strobe.
  - page_data changes on a stable page appear on out_fields 1 cycle later.
- out_blank is registered with 1-cycle latency from tick.
- Reset mid-operation: all state returns to reset values immediately; no partial page update survives.

Decomposition:
- Shared package display_pkg:
  - state enum {MANUAL, AUTO, EDIT};
  - default scan-code constants (KEY_TIME, KEY_TIME_ALT, KEY_DATE, KEY_NEXT);
  - page index constants PAGE_TIME=0, PAGE_DATE=1.
- One sub-module, page_timer: dwell counter plus blink toggle, driven by tick, with clear/hold inputs and a one-cycle advance output.

Test Plan:
- Reset release, N_PAGES=3, page_data page0 fields {8'h12,8'h34,8'h05} → out_page 0; out_fields = page0 two cycles after reset deassert; out_blank 0.
- key_valid with 8'h72 → out_page=1 two cycles later; then 8'h75 → out_page=0; then 8'h6C → stays 0; then 8'h1C → no change.
- KEY_NEXT pressed 3 times with N_PAGES=3 → out_page 1, 2, 0 (wrap).
- auto_en=1, DWELL=5, tick every 10 cycles → page advances after each 5th tick; KEY_DATE coincident with 5th tick → page 1, and the next advance occurs 5 ticks later.
- edit_en=1, edit_field=2 with 4 ticks → out_blank 100, 000, 100, 000; KEY_NEXT ignored; edit_field=3 → out_blank 000.
- reset asserted while AUTO with dwell count at 3 → all outputs 0 immediately; after release, state MANUAL with auto_en low.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared state encoding, default scan codes and page indices for display_page_sel
package display_pkg;
  typedef enum logic [1:0] {MANUAL, AUTO, EDIT} state_e;
  localparam logic [7:0] KEY_TIME = 8'h6C;
  localparam logic [7:0] KEY_TIME_ALT = 8'h75;
  localparam logic [7:0] KEY_DATE = 8'h72;
  localparam logic [7:0] KEY_NEXT = 8'h74;
  localparam int PAGE_TIME = 0;
  localparam int PAGE_DATE = 1;
endpackage

// File: rtl/page_timer.sv
// page_timer: auto-scroll dwell counter and edit blink phase, both paced by tick
// ports: clk, rst_n | tick_i pace pulse, run_i count dwell, clr_i clear dwell,
//        blink_en_i allow blinking | adv_o one-cycle page advance, blink_o next blink phase
module page_timer #(
  parameter int DWELL = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic run_i,
  input  logic clr_i,
  input  logic blink_en_i,
  output logic adv_o,
  output logic blink_o
);
  localparam int CW = $clog2(DWELL + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic blink_q;
  always_comb begin
    adv_o = run_i && tick_i && !clr_i && cnt_q == CW'(DWELL - 1);
    cnt_d = clr_i ? '0 : (run_i && tick_i) ? (adv_o ? '0 : cnt_q + 1'b1) : cnt_q;
    // next phase is exported so the blank mask can be registered in the same edge
    blink_o = blink_en_i && (blink_q ^ tick_i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      blink_q <= blink_o;
    end
endmodule

// File: rtl/display_page_sel.sv
// display_page_sel: selects one of N_PAGES field pages by key, auto-scroll or edit freeze
// ports: clk, rst_n | tick_i pace pulse, key_code_i/key_valid_i scan code strobe,
//        auto_en_i, edit_en_i mode levels, edit_field_i blinking field, page_data_i packed pages
//        | out_fields_o selected fields, out_page_o current page, out_blank_o blank mask
module display_page_sel #(
  parameter int N_PAGES = 2,
  parameter int N_FIELDS = 3,
  parameter int FIELD_W = 8,
  parameter int KEY_W = 8,
  parameter logic [KEY_W-1:0] KEY_TIME = KEY_W'(display_pkg::KEY_TIME),
  parameter logic [KEY_W-1:0] KEY_TIME_ALT = KEY_W'(display_pkg::KEY_TIME_ALT),
  parameter logic [KEY_W-1:0] KEY_DATE = KEY_W'(display_pkg::KEY_DATE),
  parameter logic [KEY_W-1:0] KEY_NEXT = KEY_W'(display_pkg::KEY_NEXT),
  parameter int DWELL = 5,
  localparam int PW = $clog2(N_PAGES),
  localparam int EW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic [KEY_W-1:0] key_code_i,
  input  logic key_valid_i,
  input  logic auto_en_i,
  input  logic edit_en_i,
  input  logic [EW-1:0] edit_field_i,
  input  logic [N_PAGES*N_FIELDS*FIELD_W-1:0] page_data_i,
  output logic [N_FIELDS*FIELD_W-1:0] out_fields_o,
  output logic [PW-1:0] out_page_o,
  output logic [N_FIELDS-1:0] out_blank_o
);
  import display_pkg::*;
  state_e state_q, state_d;
  logic [PW-1:0] page_q, page_d, page_inc, key_page;
  logic [N_FIELDS-1:0] blank_d;
  logic key_hit, adv, blink;
  always_comb begin
    state_d = edit_en_i ? EDIT : auto_en_i ? AUTO : MANUAL;
    page_inc = (page_q == PW'(N_PAGES - 1)) ? '0 : page_q + 1'b1;
    key_page = (key_code_i == KEY_TIME || key_code_i == KEY_TIME_ALT) ? PW'(PAGE_TIME) :
               (key_code_i == KEY_DATE) ? PW'(PAGE_DATE) : page_inc;
    key_hit = key_valid_i && state_d != EDIT &&
              (key_code_i inside {KEY_TIME, KEY_TIME_ALT, KEY_DATE, KEY_NEXT});
    // a key arriving with a dwell advance takes precedence
    page_d = key_hit ? key_page : adv ? page_inc : page_q;
    blank_d = (state_d == EDIT && int'(edit_field_i) < N_FIELDS && blink) ?
              N_FIELDS'(1) << edit_field_i : '0;
  end
  page_timer #(.DWELL(DWELL)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .tick_i(tick_i),
    .run_i(state_d == AUTO),
    .clr_i(state_d == EDIT || (state_d == AUTO && state_q != AUTO) || key_hit),
    .blink_en_i(state_d == EDIT),
    .adv_o(adv),
    .blink_o(blink)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= MANUAL;
      page_q <= '0;
      out_fields_o <= '0;
      out_page_o <= '0;
      out_blank_o <= '0;
    end else begin
      state_q <= state_d;
      page_q <= page_d;
      out_fields_o <= page_data_i[int'(page_q)*N_FIELDS*FIELD_W +: N_FIELDS*FIELD_W];
      out_page_o <= page_q;
      out_blank_o <= blank_d;
    end
endmodule
